// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter sharing one naive_bus slave between N_MASTERS requesters.
// Grants pass through combinationally; read data is steered to the master granted one cycle earlier.
module naive_bus_rr_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTERS-1:0]    m_rd_req,
  input  logic [N_MASTERS*AW-1:0] m_rd_addr,
  output logic [N_MASTERS-1:0]    m_rd_gnt,
  output logic [N_MASTERS*DW-1:0] m_rd_data,
  input  logic [N_MASTERS-1:0]    m_wr_req,
  input  logic [N_MASTERS*AW-1:0] m_wr_addr,
  input  logic [N_MASTERS*DW-1:0] m_wr_data,
  input  logic [N_MASTERS*4-1:0]  m_wr_be,
  output logic [N_MASTERS-1:0]    m_wr_gnt,
  output logic                    s_rd_req,
  output logic [AW-1:0]           s_rd_addr,
  input  logic                    s_rd_gnt,
  input  logic [DW-1:0]           s_rd_data,
  output logic                    s_wr_req,
  output logic [AW-1:0]           s_wr_addr,
  output logic [DW-1:0]           s_wr_data,
  output logic [3:0]              s_wr_be,
  input  logic                    s_wr_gnt
);

  localparam int unsigned PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 own_vld_q, own_vld_d;
  logic [PW-1:0]        own_idx_q, own_idx_d;
  logic [N_MASTERS-1:0] active;
  logic                 sel_vld;
  logic [PW-1:0]        sel;
  logic                 rd_hit;
  logic                 wr_hit;

  // (base + k) mod N_MASTERS, used for the rotating search and the pointer advance
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
    return PW'((32'(base) + k) % N_MASTERS);
  endfunction

  assign active = m_rd_req | m_wr_req;

  // First active master starting at ptr
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (!sel_vld && active[rr_idx(ptr_q, k)]) begin
        sel_vld = 1'b1;
        sel     = rr_idx(ptr_q, k);
      end
    end
  end

  // Forward the selected master's both directions to the slave
  always_comb begin
    s_rd_req  = sel_vld & m_rd_req[sel];
    s_wr_req  = sel_vld & m_wr_req[sel];
    s_rd_addr = m_rd_addr[AW*32'(sel) +: AW];
    s_wr_addr = m_wr_addr[AW*32'(sel) +: AW];
    s_wr_data = m_wr_data[DW*32'(sel) +: DW];
    s_wr_be   = m_wr_be[4*32'(sel) +: 4];
    rd_hit    = s_rd_req & s_rd_gnt;
    wr_hit    = s_wr_req & s_wr_gnt;
    m_rd_gnt  = '0;
    m_wr_gnt  = '0;
    if (rd_hit) m_rd_gnt[sel] = 1'b1;
    if (wr_hit) m_wr_gnt[sel] = 1'b1;
  end

  // Next pointer and read-owner tracking
  always_comb begin
    ptr_d     = ptr_q;
    own_vld_d = rd_hit;
    own_idx_d = own_idx_q;
    if (rd_hit || wr_hit) ptr_d = rr_idx(sel, 1);
    if (rd_hit) own_idx_d = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      own_vld_q <= 1'b0;
      own_idx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      own_vld_q <= own_vld_d;
      own_idx_q <= own_idx_d;
    end
  end

  // Steer returning read data to the owner of last cycle's grant
  always_comb begin
    m_rd_data = '0;
    if (own_vld_q) m_rd_data[DW*32'(own_idx_q) +: DW] = s_rd_data;
  end

endmodule
